instr_fetch_unit: RTL

//  Fetch stage directly upstream of the cpu core. Drives the instruction-memory read port from an

---
 rtl/instr_fetch_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives the imem read port from a fetch PC and buffers returned words in a prefetch FIFO.
// Optional FETCH_PERF_EN macro adds perf_fetched/perf_stall counters.
module instr_fetch_unit #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = 32'hE1A00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] start_pc,
    input  logic        redirect,
    input  logic [10:0] redirect_pc,
    output logic        imem_rd_en,
    output logic [10:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [10:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 32;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               inflight_q, inflight_d;
    logic               tag_q, tag_d;
    logic               epoch_q, epoch_d;
    logic [AW-1:0]      issue_pc_q, issue_pc_d;
    logic [AW-1:0]      last_pc_q, last_pc_d;
    logic               issue;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     occupancy;

    logic [DW-1:0]      data_mem [DEPTH];
    logic [AW-1:0]      pc_mem   [DEPTH];

    // State register and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
            epoch_q    <= 1'b0;
            issue_pc_q <= '0;
            last_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            epoch_q    <= epoch_d;
            issue_pc_q <= issue_pc_d;
            last_pc_q  <= last_pc_d;
        end
    end

    // Credit check counts the returning word but takes no credit for a same-cycle pop
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        epoch_d    = epoch_q;
        issue_pc_d = issue_pc_q;
        last_pc_d  = last_pc_q;
        issue      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;

        if (count_q != '0) begin
            last_pc_d = pc_mem[rd_ptr_q];
        end

        case (state_q)
            S_BOOT: begin
                fetch_pc_d = start_pc;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (redirect) begin
                    // Flush wins over push/pop; epoch flip kills any response still in flight
                    count_d    = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    epoch_d    = ~epoch_q;
                    fetch_pc_d = redirect_pc;
                end else begin
                    push  = inflight_q && (tag_q == epoch_q);
                    pop   = (count_q != '0) && instr_ready;
                    issue = occupancy < DEPTH_V;
                    if (issue) begin
                        inflight_d = 1'b1;
                        tag_d      = epoch_q;
                        issue_pc_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + AW'(1);
                    end
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // FIFO storage, no reset needed: entries are only read when counted valid
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_data;
            pc_mem[wr_ptr_q]   <= issue_pc_q;
        end
    end

    assign imem_rd_en  = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr_q] : NOP;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : last_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Push and stall-cycle counters; both naturally hold while in BOOT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if ((state_q == S_RUN) && !issue && !redirect) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
